// File: rtl/spi_frame_sender_pkg.sv
// Shared constants and state encoding for the hub75 SPI frame sender.
package spi_frame_sender_pkg;

  localparam int unsigned BITS_PER_PIXEL_DEF = 32;
  localparam int unsigned PANEL_WIDTH        = 64;
  localparam int unsigned PANEL_HEIGHT       = 32;
  localparam int unsigned PIXELS_DEF         = PANEL_WIDTH * PANEL_HEIGHT;
  localparam int unsigned ADDR_W_DEF         = $clog2(PIXELS_DEF);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StFetch,
    StLoad,
    StLow,
    StHigh,
    StTail,
    StEnd
  } state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Counts CLK_DIV cycles of the current SPI phase; phase_end marks the last one.
module spi_phase_timer
  import spi_frame_sender_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic phase_end
);

  localparam int unsigned CntW = width_of(CLK_DIV);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  // Saturates at the last count so a held state keeps phase_end asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (!phase_end) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign phase_end = (cnt_q == LastCnt);

endmodule

// File: rtl/spi_frame_sender.sv
// SPI master streaming one frame of pixel words, MSB first, into the hub75 controller.
module spi_frame_sender
  import spi_frame_sender_pkg::*;
#(
  parameter int unsigned BITS_PER_PIXEL = BITS_PER_PIXEL_DEF,
  parameter int unsigned PIXELS         = PIXELS_DEF,
  parameter int unsigned CLK_DIV        = 1,
  parameter int unsigned ADDR_W         = ADDR_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      pix_rd,
  output logic [ADDR_W-1:0]         pix_addr,
  input  logic [BITS_PER_PIXEL-1:0] pix_data,
  output logic                      spi_clk,
  output logic                      spi_mosi,
  output logic                      spi_ss
);

  localparam int unsigned BitW = width_of(BITS_PER_PIXEL);
  localparam logic [BitW-1:0]   LastBit = BitW'(BITS_PER_PIXEL - 1);
  localparam logic [ADDR_W-1:0] LastPix = ADDR_W'(PIXELS - 1);

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         pix_cnt_q, pix_cnt_d;
  logic [BitW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [BITS_PER_PIXEL-1:0] shreg_q, shreg_d;
  logic                      phase_end;
  logic                      timer_clear;

  // Every state entry restarts the phase count.
  assign timer_clear = (state_d != state_q);

  spi_phase_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .phase_end(phase_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pix_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    unique case (state_q)
      StIdle: begin
        pix_cnt_d = '0;
        bit_cnt_d = '0;
        if (start) state_d = StSetup;
      end
      StSetup: begin
        if (phase_end) state_d = StFetch;
      end
      StFetch: begin
        state_d = StLoad;
      end
      StLoad: begin
        shreg_d   = pix_data;
        bit_cnt_d = '0;
        state_d   = StLow;
      end
      StLow: begin
        if (phase_end) state_d = StHigh;
      end
      StHigh: begin
        if (phase_end) begin
          if (bit_cnt_q != LastBit) begin
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = StLow;
          end else if (pix_cnt_q != LastPix) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
            state_d   = StFetch;
          end else begin
            state_d = StTail;
          end
        end
      end
      StTail: begin
        if (phase_end) state_d = StEnd;
      end
      StEnd: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Abort drops the frame without passing through END, so no done pulse.
    if (abort && (state_q != StIdle)) state_d = StIdle;
  end

  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StEnd);
    pix_rd   = (state_q == StFetch);
    pix_addr = pix_cnt_q;
    spi_clk  = (state_q == StHigh);
    spi_ss   = (state_q == StIdle) || (state_q == StEnd);
    spi_mosi = ((state_q == StLow) || (state_q == StHigh)) ? shreg_q[BITS_PER_PIXEL-1] : 1'b0;
  end

endmodule

// File: tb/tb_spi_frame_sender.sv
// Scoreboard bench: expected words/done cycles queued at start, checked by SPI-side monitors.
module tb_spi_frame_sender;

  localparam int BPP  = 32;
  localparam int NPIX = 4;
  localparam int AW   = 2;
  localparam int PIXC = 2 + 2 * BPP;  // cycles per pixel at CLK_DIV=1

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          start3 = 1'b0;
  logic          abort3 = 1'b0;
  logic          busy, done, pix_rd, spi_clk, spi_mosi, spi_ss;
  logic          busy3, done3, pix_rd3, spi_clk3, spi_mosi3, spi_ss3;
  logic [AW-1:0] pix_addr, pix_addr3;
  logic [31:0]   pix_data = '0;
  logic [31:0]   pix_data3 = '0;
  logic [31:0]   mem [NPIX];

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          start3_c = 0;
  logic [31:0] exp_q [$];
  int          done_q [$];

  spi_frame_sender #(
    .BITS_PER_PIXEL(BPP),
    .PIXELS        (NPIX),
    .CLK_DIV       (1),
    .ADDR_W        (AW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .pix_rd  (pix_rd),
    .pix_addr(pix_addr),
    .pix_data(pix_data),
    .spi_clk (spi_clk),
    .spi_mosi(spi_mosi),
    .spi_ss  (spi_ss)
  );

  spi_frame_sender #(
    .BITS_PER_PIXEL(BPP),
    .PIXELS        (NPIX),
    .CLK_DIV       (3),
    .ADDR_W        (AW)
  ) dut3 (
    .clk     (clk),
    .reset   (reset),
    .start   (start3),
    .abort   (abort3),
    .busy    (busy3),
    .done    (done3),
    .pix_rd  (pix_rd3),
    .pix_addr(pix_addr3),
    .pix_data(pix_data3),
    .spi_clk (spi_clk3),
    .spi_mosi(spi_mosi3),
    .spi_ss  (spi_ss3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (pix_rd) pix_data <= mem[pix_addr];
  always @(posedge clk) if (pix_rd3) pix_data3 <= mem[pix_addr3];

  function automatic int frame_len(input int div);
    return div + NPIX * (2 + 2 * BPP * div) + div + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic push_frame(input int nwords, input int start_c, input bit expect_done);
    for (int i = 0; i < nwords; i++) exp_q.push_back(mem[i]);
    if (expect_done) done_q.push_back(start_c + frame_len(1));
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < NPIX; i++) mem[i] = $urandom();
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_bit(name, busy, 1'b0);
  endtask

  // Monitor for the CLK_DIV=1 instance: rebuilds words from rising spi_clk edges.
  logic        m_pclk = 1'b0;
  logic        m_pss = 1'b1;
  logic        m_pmosi = 1'b0;
  logic [31:0] m_word = '0;
  int          m_nbits = 0;
  int          m_edges = 0;

  initial begin : mon1
    forever begin
      @(negedge clk);
      if (spi_ss) m_nbits = 0;
      if (!spi_ss && m_pss) m_edges = 0;
      if (spi_clk && !m_pclk) begin
        check_bit("ss_low_at_edge", spi_ss, 1'b0);
        m_word = {m_word[30:0], spi_mosi};
        m_nbits++;
        m_edges++;
        if (m_nbits == BPP) begin
          m_nbits = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL word_extra: got 0x%08h, expected no word", m_word);
          end else begin
            check("word", m_word, exp_q.pop_front());
          end
        end
      end
      if ((spi_mosi !== m_pmosi) && spi_clk) check_bit("mosi_change_clk_low", spi_clk, 1'b0);
      if (pix_rd) check_bit("pix_addr_range", 32'(pix_addr) < NPIX, 1'b1);
      if (done) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done at cycle %0d, expected none", cyc);
        end else begin
          check("done_cycle", cyc, done_q.pop_front());
        end
        check("edges_per_frame", m_edges, NPIX * BPP);
      end
      m_pclk  = spi_clk;
      m_pss   = spi_ss;
      m_pmosi = spi_mosi;
    end
  end

  // Monitor for the CLK_DIV=3 instance: phase lengths, mosi setup, content, done time.
  logic        n_pclk = 1'b0;
  logic        n_pmosi = 1'b0;
  logic [31:0] n_word = '0;
  int          n_run = 0;
  int          n_stab = 0;
  int          n_bits = 0;

  initial begin : mon3
    forever begin
      @(negedge clk);
      n_stab = (spi_mosi3 === n_pmosi) ? n_stab + 1 : 1;
      if (spi_clk3 !== n_pclk) begin
        if (spi_clk3) begin
          checks++;
          if (n_stab < 4) begin
            errors++;
            $display("FAIL mosi3_setup: got %0d stable cycles, expected >= 3", n_stab - 1);
          end
          if (n_bits % BPP != 0) check("clk3_low_len", n_run, 3);
          n_word = {n_word[30:0], spi_mosi3};
          n_bits++;
          if (n_bits % BPP == 0) begin
            if (n_bits / BPP <= NPIX) check("word3", n_word, mem[n_bits/BPP-1]);
            else check("word3_count", n_bits / BPP, NPIX);
          end
        end else begin
          check("clk3_high_len", n_run, 3);
        end
        n_run = 1;
      end else begin
        n_run++;
      end
      if (done3) begin
        check("done3_cycle", cyc, start3_c + frame_len(3));
        check("edges3_per_frame", n_bits, NPIX * BPP);
      end
      n_pclk  = spi_clk3;
      n_pmosi = spi_mosi3;
    end
  end

  initial begin : stim
    int c;
    int n;
    mem[0] = 32'hA500_0001;
    mem[1] = 32'hFFFF_FFFF;
    mem[2] = 32'h0000_0000;
    mem[3] = 32'h8000_0000;
    repeat (2) @(negedge clk);
    check_bit("rst_spi_clk", spi_clk, 1'b0);
    check_bit("rst_spi_mosi", spi_mosi, 1'b0);
    check_bit("rst_spi_ss", spi_ss, 1'b1);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_pix_rd", pix_rd, 1'b0);
    check("rst_pix_addr", 32'(pix_addr), 32'd0);
    check_bit("rst_spi_ss3", spi_ss3, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    // Fixed image on both instances; a start coinciding with done is dropped.
    c = cyc;
    start = 1'b1;
    start3 = 1'b1;
    start3_c = c;
    push_frame(NPIX, c, 1'b1);
    @(negedge clk);
    start = 1'b0;
    start3 = 1'b0;
    check_bit("busy_after_start", busy, 1'b1);
    check_bit("busy3_after_start", busy3, 1'b1);
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_bit("frame_a_done_seen", done, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_bit("start_at_done_ignored", busy, 1'b0);
    n = 0;
    while (busy3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_bit("frame3_idle", busy3, 1'b0);

    // Second start mid-frame is ignored.
    randomize_mem();
    @(negedge clk);
    c = cyc;
    start = 1'b1;
    push_frame(NPIX, c, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_cycle(c + 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("frame_b_idle", 400);

    // Abort during bit 17 of pixel 2.
    randomize_mem();
    @(negedge clk);
    c = cyc;
    start = 1'b1;
    push_frame(2, c, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_cycle(c + 2 + 2 * PIXC + 2 + 2 * 17);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_bit("abort_spi_ss", spi_ss, 1'b1);
    check_bit("abort_spi_clk", spi_clk, 1'b0);
    check_bit("abort_busy", busy, 1'b0);
    repeat (5) @(negedge clk);

    // start and abort together in IDLE: start wins, frame from pixel 0.
    randomize_mem();
    @(negedge clk);
    c = cyc;
    start = 1'b1;
    abort = 1'b1;
    push_frame(NPIX, c, 1'b1);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_bit("start_beats_abort", busy, 1'b1);
    wait_idle("frame_d_idle", 400);

    // Asynchronous reset during HIGH of bit 5, pixel 1.
    randomize_mem();
    @(negedge clk);
    c = cyc;
    start = 1'b1;
    push_frame(1, c, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_cycle(c + 2 + PIXC + 2 + 2 * 5 + 1);
    check_bit("in_high_before_reset", spi_clk, 1'b1);
    #1 reset = 1'b1;
    #1;
    check_bit("arst_spi_clk", spi_clk, 1'b0);
    check_bit("arst_spi_mosi", spi_mosi, 1'b0);
    check_bit("arst_spi_ss", spi_ss, 1'b1);
    check_bit("arst_busy", busy, 1'b0);
    check_bit("arst_done", done, 1'b0);
    check_bit("arst_pix_rd", pix_rd, 1'b0);
    check("arst_pix_addr", 32'(pix_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Random images with random idle gaps.
    for (int f = 0; f < 4; f++) begin
      randomize_mem();
      repeat ($urandom_range(1, 6)) @(negedge clk);
      c = cyc;
      start = 1'b1;
      push_frame(NPIX, c, 1'b1);
      @(negedge clk);
      start = 1'b0;
      wait_idle("frame_rand_idle", 400);
    end

    repeat (3) @(negedge clk);
    check("words_outstanding", exp_q.size(), 32'd0);
    check("dones_outstanding", done_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
